// File: rtl/et_pkg.sv
// Shared types and bit helpers for the early-terminating stochastic number generator.
package et_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } et_state_t;

  // Helpers work on a 32-bit container so that any WIDTH up to 32 can reuse them.
  localparam int MAXW = 32;

  function automatic logic [MAXW-1:0] bitrev(input logic [MAXW-1:0] v, input int w);
    logic [MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

  function automatic logic [6:0] popcount(input logic [MAXW-1:0] m);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < MAXW; i++) begin
      c = c + 7'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/et_sng.sv
// Early-terminating stochastic number generator: serialises Bx as a bit-reversed-counter
// stream of length 2^(WIDTH-k), k being the trailing-zero count given by the tzd mask z.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | streaming bits of bx_reg, one per accepted beat
module et_sng
  import et_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Bx,
  input  logic [WIDTH-1:0] z,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [WIDTH:0]   out_len
);

  et_state_t        state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] bx_reg, bx_nxt;
  logic [WIDTH:0]   len_reg, len_nxt;

  logic [MAXW-1:0]  cnt_rev;
  logic             rev_lt;
  logic             is_last;
  logic [WIDTH:0]   len_new;
  int               shift;

  // Only the top WIDTH-k bits of bitrev(cnt) move while cnt < L, which is what
  // makes the truncated stream carry exactly Bx>>k ones.
  assign cnt_rev = bitrev(MAXW'(cnt), WIDTH);
  assign rev_lt  = cnt_rev < MAXW'(bx_reg);
  assign is_last = ({1'b0, cnt} == (len_reg - (WIDTH+1)'(1)));
  assign shift   = WIDTH - int'(popcount(MAXW'(z)));
  assign len_new = (WIDTH+1)'(1) << shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bx_reg  <= '0;
      len_reg <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bx_reg  <= bx_nxt;
      len_reg <= len_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bx_nxt    = bx_reg;
    len_nxt   = len_reg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    out_len   = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bx_nxt    = Bx;
          len_nxt   = len_new;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        out_valid = 1'b1;
        out_bit   = rev_lt;
        out_last  = is_last;
        out_len   = len_reg;
        if (out_ready) begin
          if (is_last) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + WIDTH'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_et_sng.sv
// Self-checking bench for et_sng (WIDTH=8) against a density/bit-reversal reference model.
module tb_et_sng;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] Bx = '0;
  logic [7:0] z = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic [8:0] out_len;

  et_sng #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .Bx(Bx), .z(z), .in_valid(in_valid), .in_ready(in_ready),
    .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_len(out_len)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  bit got_q[$];
  bit exp_q[$];
  int got_last;
  int len_seen;
  bit len_bad, stab_bad, ir_bad, tmo;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rev8(input int i);
    int r;
    r = 0;
    for (int b = 0; b < 8; b++) r += ((i >> b) & 1) << (7 - b);
    return r;
  endfunction

  function automatic int k_of(input logic [7:0] zz);
    int k;
    k = 0;
    for (int b = 0; b < 8; b++) if (zz[b]) k++;
    return k;
  endfunction

  function automatic logic [7:0] tz_mask(input logic [7:0] bx);
    if (bx == 0) return 8'hFF;
    return (bx & (~bx + 8'd1)) - 8'd1;
  endfunction

  task automatic model(input logic [7:0] bx, input logic [7:0] zz);
    int len;
    exp_q.delete();
    len = 1 << (8 - k_of(zz));
    for (int i = 0; i < len; i++) exp_q.push_back(rev8(i) < int'(bx));
  endtask

  function automatic int packed_bits();
    int p;
    p = 0;
    foreach (got_q[i]) p = (p << 1) | int'(got_q[i]);
    return p;
  endfunction

  function automatic int ones_of_got();
    int n;
    n = 0;
    foreach (got_q[i]) n += int'(got_q[i]);
    return n;
  endfunction

  function automatic int seq_diff();
    int d;
    d = (got_q.size() == exp_q.size()) ? 0 : 1000;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] != exp_q[i]) d++;
    return d;
  endfunction

  task automatic send(input logic [7:0] bx, input logic [7:0] zz);
    Bx = bx;
    z = zz;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic collect(input bit rnd);
    got_q.delete();
    got_last = -1;
    len_seen = int'(out_len);
    len_bad = 0;
    stab_bad = 0;
    ir_bad = 0;
    tmo = 1;
    for (int c = 0; c < 3000; c++) begin
      bit rdy, fin;
      logic pb, pl;
      logic [8:0] plen;
      rdy = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (rnd) begin
        in_valid = 1'($urandom_range(0, 1));
        Bx = 8'($urandom);
        z = 8'($urandom);
      end
      if (out_valid !== 1'b1) break;
      if (in_ready !== 1'b0) ir_bad = 1;
      if (int'(out_len) != len_seen) len_bad = 1;
      pb = out_bit;
      pl = out_last;
      plen = out_len;
      fin = rdy && (out_last === 1'b1);
      if (rdy) got_q.push_back(out_bit);
      tick();
      if (fin) begin
        got_last = got_q.size() - 1;
        tmo = 0;
        break;
      end
      if (!rdy && (out_valid !== 1'b1 || out_bit !== pb || out_last !== pl || out_len !== plen))
        stab_bad = 1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_bit !== 1'b0) begin n_fail++; $display("FAIL reset_out_bit got=%b exp=0", out_bit); end
    n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    n_tests++; if (out_len !== 9'd0) begin n_fail++; $display("FAIL reset_out_len got=%0d exp=0", out_len); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_len4();
    send(8'h40, 8'h3F);
    collect(0);
    n_tests++; if (tmo) begin n_fail++; $display("FAIL len4_timeout got=no_last exp=last"); end
    n_tests++; if (got_q.size() != 4) begin n_fail++; $display("FAIL len4_count got=%0d exp=4", got_q.size()); end
    n_tests++; if (packed_bits() != 'b1000) begin n_fail++; $display("FAIL len4_bits got=%b exp=1000", packed_bits()); end
    n_tests++; if (got_last != 3) begin n_fail++; $display("FAIL len4_last_idx got=%0d exp=3", got_last); end
    n_tests++; if (len_seen != 4 || len_bad) begin n_fail++; $display("FAIL len4_out_len got=%0d exp=4", len_seen); end
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL len4_idle_after got=%b%b exp=10", in_ready, out_valid); end
  endtask

  task automatic test_len8();
    send(8'h60, 8'h1F);
    collect(0);
    n_tests++; if (tmo || packed_bits() != 'b10101000 || got_q.size() != 8) begin n_fail++; $display("FAIL len8_bits got=%b n=%0d exp=10101000 n=8", packed_bits(), got_q.size()); end
    n_tests++; if (len_seen != 8) begin n_fail++; $display("FAIL len8_out_len got=%0d exp=8", len_seen); end
    n_tests++; if (ones_of_got() != 3) begin n_fail++; $display("FAIL len8_ones got=%0d exp=3", ones_of_got()); end
  endtask

  task automatic test_zero();
    send(8'h00, 8'hFF);
    n_tests++; if (out_len !== 9'd1 || out_last !== 1'b1 || out_bit !== 1'b0) begin n_fail++; $display("FAIL zero_beat got=len%0d last%b bit%b exp=len1 last1 bit0", out_len, out_last, out_bit); end
    collect(0);
    n_tests++; if (tmo || got_q.size() != 1 || got_last != 0) begin n_fail++; $display("FAIL zero_count got=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_full();
    send(8'hFF, 8'h00);
    collect(0);
    n_tests++; if (tmo || got_q.size() != 256) begin n_fail++; $display("FAIL full_count got=%0d exp=256", got_q.size()); end
    n_tests++; if (ones_of_got() != 255) begin n_fail++; $display("FAIL full_ones got=%0d exp=255", ones_of_got()); end
    n_tests++; if (got_q.size() == 0 || got_q[got_q.size()-1] != 1'b0) begin n_fail++; $display("FAIL full_final_bit got=1 exp=0"); end
    n_tests++; if (len_seen != 256 || len_bad) begin n_fail++; $display("FAIL full_out_len got=%0d exp=256", len_seen); end
    n_tests++; if (ir_bad) begin n_fail++; $display("FAIL full_in_ready got=1 exp=0 during run"); end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 4; r++) begin
      send(8'h60, 8'h1F);
      collect(1);
      n_tests++; if (tmo || packed_bits() != 'b10101000 || got_q.size() != 8) begin n_fail++; $display("FAIL bp_bits got=%b n=%0d exp=10101000 n=8", packed_bits(), got_q.size()); end
      n_tests++; if (stab_bad || len_bad) begin n_fail++; $display("FAIL bp_stable got=changed exp=held"); end
      n_tests++; if (ir_bad) begin n_fail++; $display("FAIL bp_in_ready got=1 exp=0 during run"); end
      tick();
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ignored_in_valid got=valid%b ready%b exp=valid0 ready1", out_valid, in_ready); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic [7:0] bx, zz;
      int k;
      bx = 8'($urandom);
      if (t % 4 == 0) bx = bx & 8'hF0;
      zz = (t % 6 == 5) ? 8'($urandom) : tz_mask(bx);
      k = k_of(zz);
      model(bx, zz);
      send(bx, zz);
      collect(1);
      n_tests++; if (tmo || seq_diff() != 0) begin n_fail++; $display("FAIL rand_seq bx=%h z=%h got_n=%0d exp_n=%0d diff=%0d", bx, zz, got_q.size(), exp_q.size(), seq_diff()); end
      n_tests++; if (len_seen != (1 << (8 - k)) || stab_bad || len_bad) begin n_fail++; $display("FAIL rand_len bx=%h got=%0d exp=%0d", bx, len_seen, 1 << (8 - k)); end
      if (zz == tz_mask(bx)) begin
        n_tests++; if (ones_of_got() != (int'(bx) >> k)) begin n_fail++; $display("FAIL rand_ones bx=%h got=%0d exp=%0d", bx, ones_of_got(), int'(bx) >> k); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int beats;
    send(8'h81, 8'h00);
    beats = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid === 1'b1) beats++;
      tick();
    end
    n_tests++; if (beats != 10) begin n_fail++; $display("FAIL mid_beats got=%0d exp=10", beats); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_len !== 9'd0) begin n_fail++; $display("FAIL mid_reset got=valid%b ready%b len%0d exp=valid0 ready1 len0", out_valid, in_ready, out_len); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_resume got=%b exp=0", out_valid); end
    send(8'h40, 8'h3F);
    collect(0);
    n_tests++; if (tmo || packed_bits() != 'b1000 || got_q.size() != 4) begin n_fail++; $display("FAIL mid_new_bits got=%b n=%0d exp=1000 n=4", packed_bits(), got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_len4();
    tick();
    test_len8();
    tick();
    test_zero();
    tick();
    test_full();
    tick();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
